// File: rtl/mem_server_sync.sv
// Memory node for the NoC CNN accelerator: filter banks, ifmap and result buffer,
// serving packet read requests through a buffered response port.
module mem_server_sync #(
  parameter int unsigned NODE_W      = 5,
  parameter int unsigned VAL_W       = 8,
  parameter int unsigned PKT_W       = 2 + 2 * NODE_W + VAL_W,
  parameter int unsigned FILTER_SIZE = 3,
  parameter int unsigned NUM_FILTERS = 3,
  parameter int unsigned IFMAP_SIZE  = 7,
  parameter int unsigned OUT_SIZE    = 5,
  parameter int unsigned RESP_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NODE_W-1:0] node_id,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic              load_sel,
  input  logic [VAL_W-1:0]  load_addr,
  input  logic [VAL_W-1:0]  load_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [PKT_W-1:0]  req_pkt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [PKT_W-1:0]  rsp_pkt,
  input  logic              rd_en,
  input  logic [VAL_W-1:0]  rd_addr,
  output logic [VAL_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic              done,
  input  logic              done_ack,
  output logic              err
);

  localparam int unsigned FILT_N = FILTER_SIZE * FILTER_SIZE * NUM_FILTERS;
  localparam int unsigned IFM_N  = IFMAP_SIZE * IFMAP_SIZE;
  localparam int unsigned RES_N  = OUT_SIZE * OUT_SIZE * NUM_FILTERS;
  localparam int unsigned FI_W   = $clog2(FILT_N);
  localparam int unsigned II_W   = $clog2(IFM_N);
  localparam int unsigned RI_W   = $clog2(RES_N);
  localparam int unsigned RP_W   = $clog2(RES_N + 1);
  localparam int unsigned PTR_W  = $clog2(RESP_DEPTH);
  localparam int unsigned CNT_W  = $clog2(RESP_DEPTH + 1);

  localparam logic [VAL_W-1:0] FiltLim   = VAL_W'(FILT_N);
  localparam logic [VAL_W-1:0] IfmLim    = VAL_W'(IFM_N);
  localparam logic [VAL_W-1:0] ResLim    = VAL_W'(RES_N);
  localparam logic [VAL_W-1:0] FiltLast  = VAL_W'(FILT_N - 1);
  localparam logic [VAL_W-1:0] IfmLast   = VAL_W'(IFM_N - 1);
  localparam logic [RP_W-1:0]  ResLast   = RP_W'(RES_N - 1);
  localparam logic [PTR_W-1:0] PtrLast   = PTR_W'(RESP_DEPTH - 1);
  localparam logic [CNT_W-1:0] FifoDepth = CNT_W'(RESP_DEPTH);

  typedef enum logic [1:0] {
    PktResWr   = 2'b00,
    PktIfmRd   = 2'b01,
    PktFiltRd  = 2'b10,
    PktIllegal = 2'b11
  } pkt_type_e;

  logic [VAL_W-1:0] filt_mem [FILT_N];
  logic [VAL_W-1:0] ifm_mem  [IFM_N];
  logic [VAL_W-1:0] res_mem  [RES_N];
  logic [PKT_W-1:0] fifo_mem [RESP_DEPTH];

  logic             filt_loaded_q, ifm_loaded_q, done_q, err_q, rd_valid_q;
  logic [VAL_W-1:0] rd_data_q;
  logic [RP_W-1:0]  res_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  pkt_type_e         pkt_type;
  logic [NODE_W-1:0] req_src;
  logic [NODE_W-1:0] unused_dst;
  logic [VAL_W-1:0]  req_pay, rd_val, rb_val;
  logic [PKT_W-1:0]  rsp_new;
  logic              accept, push, pop, rd_oob, res_wr, illegal, ack;
  logic              load_filt, load_ifm, load_oob;

  // Request decode and array lookup; the read uses pre-edge contents so a
  // coincident preload returns the old value.
  always_comb begin
    pkt_type   = pkt_type_e'(req_pkt[PKT_W-1 -: 2]);
    unused_dst = req_pkt[PKT_W-3 -: NODE_W];
    req_src    = req_pkt[VAL_W +: NODE_W];
    req_pay    = req_pkt[VAL_W-1:0];
    accept     = req_valid & req_ready;
    push       = 1'b0;
    rd_oob     = 1'b0;
    rd_val     = '0;
    if (accept) begin
      unique case (pkt_type)
        PktIfmRd: begin
          push = 1'b1;
          if (req_pay < IfmLim) rd_val = ifm_mem[req_pay[II_W-1:0]];
          else                  rd_oob = 1'b1;
        end
        PktFiltRd: begin
          push = 1'b1;
          if (req_pay < FiltLim) rd_val = filt_mem[req_pay[FI_W-1:0]];
          else                   rd_oob = 1'b1;
        end
        default: ;
      endcase
    end
    res_wr    = accept && (pkt_type == PktResWr);
    illegal   = accept && (pkt_type == PktIllegal);
    rsp_new   = {pkt_type, req_src, node_id, rd_val};
    pop       = rsp_valid & rsp_ready;
    ack       = done_ack & done_q;
    load_filt = load_valid & ~load_sel & (load_addr < FiltLim);
    load_ifm  = load_valid & load_sel & (load_addr < IfmLim);
    load_oob  = load_valid & ~(load_filt | load_ifm);
    rb_val    = (rd_addr < ResLim) ? res_mem[rd_addr[RI_W-1:0]] : '0;
  end

  // Storage arrays
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(FILT_N); i++) filt_mem[i] <= '0;
      for (int i = 0; i < int'(IFM_N); i++)  ifm_mem[i]  <= '0;
      for (int i = 0; i < int'(RES_N); i++)  res_mem[i]  <= '0;
    end else begin
      if (load_filt) filt_mem[load_addr[FI_W-1:0]] <= load_data;
      if (load_ifm)  ifm_mem[load_addr[II_W-1:0]]  <= load_data;
      if (res_wr)    res_mem[res_ptr_q[RI_W-1:0]]  <= req_pay;
    end
  end

  // Frame control, flags and readback
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_loaded_q <= 1'b0;
      ifm_loaded_q  <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      res_ptr_q     <= '0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      if (load_filt && load_addr == FiltLast) filt_loaded_q <= 1'b1;
      // A final ifmap write on the ack edge starts the next frame immediately.
      if (load_ifm && load_addr == IfmLast) ifm_loaded_q <= 1'b1;
      else if (ack)                         ifm_loaded_q <= 1'b0;
      err_q <= err_q | load_oob | rd_oob | illegal;
      if (ack) begin
        done_q    <= 1'b0;
        res_ptr_q <= '0;
      end else if (res_wr) begin
        res_ptr_q <= res_ptr_q + RP_W'(1);
        if (res_ptr_q == ResLast) done_q <= 1'b1;
      end
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= rb_val;
    end
  end

  // Response FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(RESP_DEPTH); i++) fifo_mem[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_q] <= rsp_new;
        wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  assign load_ready = 1'b1;
  assign req_ready  = filt_loaded_q & ifm_loaded_q & ~done_q & (count_q < FifoDepth);
  assign rsp_valid  = (count_q != '0);
  assign rsp_pkt    = fifo_mem[rd_ptr_q];
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
